intr_ctl: RTL

- Memory-mapped interrupt controller on the processor IO bus. It sits beside the Key, switch and timer devices and collects their INTR lines.
- It latches rising edges as pending, masks them by an enable register, and picks one source by fixed priority.
- It drives a single IRQ/IVEC handshake to the pipeline and holds the in-service source until software writes end-of-interrupt.

---
 rtl/intr_pkg.sv | 29 ++
 rtl/prio_enc.sv | 22 ++
 rtl/intr_ctl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states, ISTAT layout.
package intr_pkg;

  localparam logic [3:0] OFS_IPEND = 4'd0;
  localparam logic [3:0] OFS_IEN   = 4'd4;
  localparam logic [3:0] OFS_ISTAT = 4'd8;
  localparam logic [3:0] OFS_IEOI  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam int ISTAT_SVC_BIT = 31;
  localparam int ISTAT_IRQ_BIT = 30;
  localparam int ISTAT_CUR_W   = 4;

  function automatic logic [31:0] istat_word(input logic svc, input logic irq,
                                             input logic [3:0] cur);
    logic [31:0] w;
    w = '0;
    w[ISTAT_SVC_BIT]     = svc;
    w[ISTAT_IRQ_BIT]     = irq;
    w[ISTAT_CUR_W-1:0]   = cur;
    return w;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of the lowest one.
module prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [3:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = 1'b0;
    idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask, fixed priority,
// single IRQ/IVEC handshake held in service until software writes end-of-interrupt.
module intr_ctl
  import intr_pkg::*;
#(
  parameter int              BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hFFFFF0C0,
  parameter int              NSRC = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic [NSRC-1:0] SRC_INTR,
  output logic            IRQ,
  output logic [3:0]      IVEC,
  input  logic            IACK
);

  logic [NSRC-1:0] r_ipend;
  logic [NSRC-1:0] r_ien;
  logic [NSRC-1:0] r_prev;
  state_t          r_state;
  logic [3:0]      r_cur;
  logic            r_irq;

  logic [BITS-1:0] w_ofs;
  logic            w_hit;
  logic            w_wr_ipend;
  logic            w_wr_ien;
  logic            w_wr_ieoi;
  logic [BITS-1:0] w_rdata;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_cand;
  logic [NSRC-1:0] w_cur_oh;
  logic [NSRC-1:0] w_clr;
  logic            w_ack;
  logic            w_cur_live;
  logic            w_any;
  logic [3:0]      w_idx;
  logic            w_unused;

  // Window decode by offset so BASE need not be 16-byte aligned.
  assign w_ofs      = ABUS - BASE;
  assign w_hit      = (w_ofs < BITS'(16)) && (w_ofs[1:0] == 2'b00);
  assign w_wr_ipend = WE && w_hit && (w_ofs[3:0] == OFS_IPEND);
  assign w_wr_ien   = WE && w_hit && (w_ofs[3:0] == OFS_IEN);
  assign w_wr_ieoi  = WE && w_hit && (w_ofs[3:0] == OFS_IEOI);

  assign w_rise = SRC_INTR & ~r_prev;
  assign w_cand = r_ipend & r_ien;

  prio_enc #(
    .N (NSRC)
  ) u_prio (
    .req (w_cand),
    .any (w_any),
    .idx (w_idx)
  );

  always_comb begin
    w_cur_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_cur_oh[i] = (r_cur == 4'(i));
    end
  end

  assign w_ack      = (r_state == ST_REQ) && IACK;
  assign w_clr      = (w_wr_ipend ? DBUS[NSRC-1:0] : '0) | (w_ack ? w_cur_oh : '0);
  assign w_cur_live = |(w_cur_oh & r_ipend & r_ien);

  // A rise always wins over a clear landing on the same edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prev  <= '0;
      r_ipend <= '0;
      r_ien   <= '0;
    end else begin
      r_prev  <= SRC_INTR;
      r_ipend <= (r_ipend & ~w_clr) | w_rise;
      if (w_wr_ien) begin
        r_ien <= DBUS[NSRC-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_cur   <= 4'd0;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cur   <= w_idx;
            r_irq   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (IACK) begin
            r_irq   <= 1'b0;
            r_state <= ST_SERVICE;
          end else if (!w_cur_live) begin
            // Software withdrew the request before the pipeline took it.
            r_irq   <= 1'b0;
            r_cur   <= 4'd0;
            r_state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (w_wr_ieoi) begin
            r_cur   <= 4'd0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_cur   <= 4'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign IRQ  = r_irq;
  assign IVEC = r_cur;

  always_comb begin
    w_rdata = '0;
    case (w_ofs[3:0])
      OFS_IPEND: w_rdata[NSRC-1:0] = r_ipend;
      OFS_IEN:   w_rdata[NSRC-1:0] = r_ien;
      OFS_ISTAT: w_rdata = BITS'(istat_word(r_state == ST_SERVICE, r_irq, r_cur));
      default:   w_rdata = '0;
    endcase
  end

  assign DBUS = (w_hit && !WE) ? w_rdata : 'z;

  assign w_unused = &{1'b0, DBUS[BITS-1:NSRC]};

endmodule
